// File: rtl/wire_rx_pkg.sv
// Shared definitions for the wire_rx receiver: debounce FSM states and
// the glitch counter width.
package wire_rx_pkg;

    typedef enum logic [1:0] {
        ST_LO   = 2'd0,
        PEND_HI = 2'd1,
        ST_HI   = 2'd2,
        PEND_LO = 2'd3
    } rx_state_t;

    localparam int GLITCH_W = 8;

endpackage

// File: rtl/wire_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit line. The chain
// resets to INIT_LEVEL so the downstream FSM sees a settled idle value.
module wire_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit INIT_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the raw line through the synchroniser chain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chain <= {SYNC_STAGES{INIT_LEVEL}};
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/wire_rx.sv
// Receiving end of a single-bit wire link: synchronise, debounce, emit
// rise/fall strobes, measure high-pulse width and count rejected glitches.
module wire_rx
    import wire_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int CNT_W       = 16,
    parameter bit INIT_LEVEL  = 1'b0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in,
    output logic                level,
    output logic                rise,
    output logic                fall,
    output logic [CNT_W-1:0]    width,
    output logic                width_valid,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    // deb_cnt value that, once incremented, reaches DEB_CYCLES
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam rx_state_t RST_STATE = INIT_LEVEL ? ST_HI : ST_LO;

    logic             s;
    rx_state_t        state, state_next;
    logic [DEB_W-1:0] deb_cnt, deb_next;
    logic             go_hi, go_lo, glitch;
    logic [CNT_W-1:0] hi_cnt, hi_next;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [GLITCH_W-1:0] sat_inc_glitch(input logic [GLITCH_W-1:0] v);
        return (&v) ? v : v + GLITCH_W'(1);
    endfunction

    wire_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .INIT_LEVEL (INIT_LEVEL)
    ) u_sync (
        .clk (clk),
        .rstn(rstn),
        .d   (in),
        .q   (s)
    );

    // Debounce FSM: decide next state and whether a change is accepted or rejected.
    always_comb begin
        state_next = state;
        deb_next   = deb_cnt;
        go_hi      = 1'b0;
        go_lo      = 1'b0;
        glitch     = 1'b0;
        case (state)
            ST_LO: begin
                if (s) begin
                    if (DEB_CYCLES == 1) begin
                        state_next = ST_HI;
                        go_hi      = 1'b1;
                        deb_next   = '0;
                    end else begin
                        state_next = PEND_HI;
                        deb_next   = DEB_W'(1);
                    end
                end
            end
            PEND_HI: begin
                if (!s) begin
                    state_next = ST_LO;
                    deb_next   = '0;
                    glitch     = 1'b1;
                end else if (deb_cnt == DEB_LAST) begin
                    state_next = ST_HI;
                    go_hi      = 1'b1;
                    deb_next   = '0;
                end else begin
                    deb_next = deb_cnt + DEB_W'(1);
                end
            end
            ST_HI: begin
                if (!s) begin
                    if (DEB_CYCLES == 1) begin
                        state_next = ST_LO;
                        go_lo      = 1'b1;
                        deb_next   = '0;
                    end else begin
                        state_next = PEND_LO;
                        deb_next   = DEB_W'(1);
                    end
                end
            end
            PEND_LO: begin
                if (s) begin
                    state_next = ST_HI;
                    deb_next   = '0;
                    glitch     = 1'b1;
                end else if (deb_cnt == DEB_LAST) begin
                    state_next = ST_LO;
                    go_lo      = 1'b1;
                    deb_next   = '0;
                end else begin
                    deb_next = deb_cnt + DEB_W'(1);
                end
            end
            default: begin
                state_next = ST_LO;
                deb_next   = '0;
            end
        endcase
    end

    // Count of cycles level has been high, including the current one.
    assign hi_next = level ? sat_inc_cnt(hi_cnt) : hi_cnt;

    // State register plus level and strobe outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= RST_STATE;
            deb_cnt <= '0;
            level   <= INIT_LEVEL;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            state   <= state_next;
            deb_cnt <= deb_next;
            rise    <= go_hi;
            fall    <= go_lo;
            if (go_hi) begin
                level <= 1'b1;
            end else if (go_lo) begin
                level <= 1'b0;
            end
        end
    end

    // Pulse-width measurement: restart on rise, publish the final count on fall.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hi_cnt      <= '0;
            width       <= '0;
            width_valid <= 1'b0;
        end else begin
            hi_cnt      <= go_hi ? '0 : hi_next;
            width_valid <= go_lo;
            if (go_lo) begin
                width <= hi_next;
            end
        end
    end

    // Saturating count of transitions rejected by the debouncer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            glitch_cnt <= '0;
        end else if (glitch) begin
            glitch_cnt <= sat_inc_glitch(glitch_cnt);
        end
    end

endmodule

// File: tb/tb_wire_rx.sv
// Bench for wire_rx: default instance (a), CNT_W=4 instance (b) sharing its
// line and reset, and an INIT_LEVEL=1 instance (c) with its own line/reset.
module tb_wire_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, in_ab, rstn_c, in_c;

    logic        level_a, rise_a, fall_a, wv_a;
    logic [15:0] width_a;
    logic [7:0]  glitch_a;
    logic        level_b, rise_b, fall_b, wv_b;
    logic [3:0]  width_b;
    logic [7:0]  glitch_b;
    logic        level_c, rise_c, fall_c, wv_c;
    logic [15:0] width_c;
    logic [7:0]  glitch_c;

    wire_rx #(.SYNC_STAGES(2), .DEB_CYCLES(4), .CNT_W(16), .INIT_LEVEL(1'b0)) dut_a (
        .clk(clk), .rstn(rstn), .in(in_ab), .level(level_a), .rise(rise_a), .fall(fall_a),
        .width(width_a), .width_valid(wv_a), .glitch_cnt(glitch_a));

    wire_rx #(.SYNC_STAGES(2), .DEB_CYCLES(4), .CNT_W(4), .INIT_LEVEL(1'b0)) dut_b (
        .clk(clk), .rstn(rstn), .in(in_ab), .level(level_b), .rise(rise_b), .fall(fall_b),
        .width(width_b), .width_valid(wv_b), .glitch_cnt(glitch_b));

    wire_rx #(.SYNC_STAGES(2), .DEB_CYCLES(4), .CNT_W(16), .INIT_LEVEL(1'b1)) dut_c (
        .clk(clk), .rstn(rstn_c), .in(in_c), .level(level_c), .rise(rise_c), .fall(fall_c),
        .width(width_c), .width_valid(wv_c), .glitch_cnt(glitch_c));

    int checks = 0;
    int passed = 0;
    int rises_a = 0, falls_a = 0, rises_c = 0, overlap = 0, wv_bad = 0;
    int last_wa = 0, last_wb = 0;

    typedef struct {
        int hi;
        int exp_rises;
        int exp_wa;
        int exp_wb;
        int exp_glitch;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // One clock, then sample 1 ns after the edge and update the monitors.
    task automatic step();
        @(posedge clk);
        #1;
        if (rise_a) rises_a++;
        if (fall_a) falls_a++;
        if (rise_c) rises_c++;
        if ((rise_a && fall_a) || (rise_b && fall_b) || (rise_c && fall_c)) overlap++;
        if ((wv_a != fall_a) || (wv_b != fall_b) || (wv_c != fall_c)) wv_bad++;
        if (wv_a) last_wa = int'(width_a);
        if (wv_b) last_wb = int'(width_b);
    endtask

    initial begin
        int r0, f0;
        vecs[0] = '{hi: 12, exp_rises: 1, exp_wa: 12, exp_wb: 12, exp_glitch: 1};
        vecs[1] = '{hi: 3,  exp_rises: 0, exp_wa: 12, exp_wb: 12, exp_glitch: 2};
        vecs[2] = '{hi: 4,  exp_rises: 1, exp_wa: 4,  exp_wb: 4,  exp_glitch: 2};
        vecs[3] = '{hi: 1,  exp_rises: 0, exp_wa: 4,  exp_wb: 4,  exp_glitch: 3};
        vecs[4] = '{hi: 40, exp_rises: 1, exp_wa: 40, exp_wb: 15, exp_glitch: 3};
        vecs[5] = '{hi: 7,  exp_rises: 1, exp_wa: 7,  exp_wb: 7,  exp_glitch: 3};

        // Reset with idle line
        rstn = 1'b0; in_ab = 1'b0; rstn_c = 1'b0; in_c = 1'b1;
        repeat (3) step();
        check("reset_level_a", level_a, 0);
        check("reset_width_a", width_a, 0);
        check("reset_glitch_a", glitch_a, 0);
        check("reset_level_c", level_c, 1);
        rstn = 1'b1;
        repeat (20) step();
        check("idle_level_a", level_a, 0);
        check("idle_rises_a", rises_a, 0);
        check("idle_falls_a", falls_a, 0);
        check("idle_width_a", width_a, 0);
        check("idle_glitch_a", glitch_a, 0);

        // 10-cycle pulse: exact rise/fall latency and width
        in_ab = 1'b1;
        repeat (5) step();
        check("lat_rise_early", rise_a, 0);
        check("lat_level_early", level_a, 0);
        step();
        check("lat_rise", rise_a, 1);
        check("lat_level_hi", level_a, 1);
        step();
        check("lat_rise_one_cycle", rise_a, 0);
        repeat (3) step();
        in_ab = 1'b0;
        repeat (5) step();
        check("lat_fall_early", fall_a, 0);
        step();
        check("lat_fall", fall_a, 1);
        check("lat_width_valid", wv_a, 1);
        check("lat_width_a", width_a, 10);
        check("lat_width_b", width_b, 10);
        step();
        check("lat_level_lo", level_a, 0);
        check("lat_wv_one_cycle", wv_a, 0);

        // Single 2-cycle glitch
        in_ab = 1'b1;
        repeat (2) step();
        in_ab = 1'b0;
        repeat (6) step();
        check("glitch_one", glitch_a, 1);
        check("glitch_level", level_a, 0);

        // Table of pulses
        for (int i = 0; i < 6; i++) begin
            r0 = rises_a;
            in_ab = 1'b1;
            repeat (vecs[i].hi) step();
            in_ab = 1'b0;
            repeat (12) step();
            check($sformatf("vec%0d_rises", i), rises_a - r0, vecs[i].exp_rises);
            check($sformatf("vec%0d_width_a", i), last_wa, vecs[i].exp_wa);
            check($sformatf("vec%0d_width_b", i), last_wb, vecs[i].exp_wb);
            check($sformatf("vec%0d_glitch", i), glitch_a, vecs[i].exp_glitch);
            check($sformatf("vec%0d_level", i), level_a, 0);
        end

        // 300 glitches saturate the counter
        r0 = rises_a;
        for (int i = 0; i < 300; i++) begin
            in_ab = 1'b1;
            repeat (2) step();
            in_ab = 1'b0;
            repeat (4) step();
        end
        check("glitch_sat_a", glitch_a, 255);
        check("glitch_sat_b", glitch_b, 255);
        check("glitch_no_rise", rises_a - r0, 0);

        // Reset while in PEND_LO
        in_ab = 1'b1;
        repeat (6) step();
        check("pend_rise", rise_a, 1);
        repeat (4) step();
        in_ab = 1'b0;
        repeat (3) step();
        check("pend_level_held", level_a, 1);
        f0 = falls_a;
        #1 rstn = 1'b0;
        #1;
        check("rst_level_now", level_a, 0);
        check("rst_no_fall", fall_a, 0);
        check("rst_width", width_a, 0);
        check("rst_glitch", glitch_a, 0);
        in_ab = 1'b1;
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (5) step();
        check("rel_level_early", level_a, 0);
        step();
        check("rel_level", level_a, 1);
        check("rel_rise", rise_a, 1);
        check("rel_no_fall", falls_a - f0, 0);

        // INIT_LEVEL=1 instance: no rise at start, width counts from release
        rstn_c = 1'b1;
        repeat (10) step();
        check("c_level_hi", level_c, 1);
        check("c_no_rise", rises_c, 0);
        in_c = 1'b0;
        repeat (5) step();
        check("c_fall_early", fall_c, 0);
        step();
        check("c_fall", fall_c, 1);
        check("c_width_valid", wv_c, 1);
        check("c_width", width_c, 16);
        step();
        check("c_level_lo", level_c, 0);

        check("rise_fall_overlap", overlap, 0);
        check("width_valid_vs_fall", wv_bad, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
